// File: rtl/ripple_mon_pkg.sv
// Shared types and helpers for the ripple counter monitor.
// Holds the monitor state encoding and the all-ones constant builder.
package ripple_mon_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  function automatic logic [31:0] all_ones(input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[i] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/cnt_sync_stable.sv
// Two-flop capture of the asynchronous ripple counter value.
// A sample counts as stable when both flops agree.
module cnt_sync_stable
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] cnt_in,
  output logic [WIDTH-1:0] sample,
  output logic             stable
);

  localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      s1 <= ONES;
      s2 <= ONES;
    end else begin
      s1 <= cnt_in;
      s2 <= s1;
    end
  end

  assign sample = s2;
  assign stable = (s1 == s2);

endmodule

// File: rtl/ripple_count_monitor.sv
// Tracks a ripple down counter in the CLK domain, emitting step/wrap
// events, a saturating wrap tally and a sticky illegal-transition flag.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              clear,
  input  logic [WIDTH-1:0]  cnt_in,
  output logic [WIDTH-1:0]  cnt_val,
  output logic              cnt_valid,
  output logic              step_pulse,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              err
);

  localparam logic [WIDTH-1:0]  ONES = WIDTH'(all_ones(WIDTH));
  localparam logic [WRAP_W-1:0] WMAX = WRAP_W'(all_ones(WRAP_W));

  state_t           state;
  logic [WIDTH-1:0] sample;
  logic             stable;
  logic [WIDTH-1:0] dec;

  cnt_sync_stable #(
    .WIDTH (WIDTH)
  ) u_sync (
    .CLK    (CLK),
    .Reset  (Reset),
    .cnt_in (cnt_in),
    .sample (sample),
    .stable (stable)
  );

  assign dec = cnt_val - 1'b1;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= INIT;
      cnt_val    <= ONES;
      cnt_valid  <= 1'b0;
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err        <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      wrap_pulse <= 1'b0;
      if (clear) begin
        state      <= INIT;
        cnt_valid  <= 1'b0;
        wrap_count <= '0;
        err        <= 1'b0;
      end else if (stable) begin
        unique case (state)
          INIT: begin
            cnt_val   <= sample;
            cnt_valid <= 1'b1;
            state     <= TRACK;
          end
          TRACK: begin
            if (sample == dec) begin
              cnt_val    <= sample;
              step_pulse <= 1'b1;
              // 0 -> all-ones is the only decrement that wraps
              if (cnt_val == '0) begin
                wrap_pulse <= 1'b1;
                if (wrap_count != WMAX)
                  wrap_count <= wrap_count + 1'b1;
              end
            end else if (sample != cnt_val) begin
              cnt_val <= sample;
              err     <= 1'b1;
              state   <= ERROR;
            end
          end
          ERROR: begin
            cnt_val <= sample;
          end
          default: begin
            state <= INIT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Directed bench for ripple_count_monitor with hand-computed expectations.
// Runs the top with a 2-bit wrap tally so saturation is reachable.
module tb_ripple_count_monitor;

  logic       CLK;
  logic       Reset;
  logic       clear;
  logic [3:0] cnt_in;
  logic [3:0] cnt_val;
  logic       cnt_valid;
  logic       step_pulse;
  logic       wrap_pulse;
  logic [1:0] wrap_count;
  logic       err;

  int passed = 0;
  int total  = 0;
  int nstep  = 0;
  int nwrap  = 0;
  int ndbl   = 0;
  logic prev_step = 1'b0;

  ripple_count_monitor #(
    .WIDTH  (4),
    .WRAP_W (2)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .clear      (clear),
    .cnt_in     (cnt_in),
    .cnt_val    (cnt_val),
    .cnt_valid  (cnt_valid),
    .step_pulse (step_pulse),
    .wrap_pulse (wrap_pulse),
    .wrap_count (wrap_count),
    .err        (err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (!Reset) begin
      if (step_pulse) nstep++;
      if (wrap_pulse) nwrap++;
      if (step_pulse && prev_step) ndbl++;
      prev_step = step_pulse;
    end else begin
      prev_step = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    cnt_in = v;
    cyc(n);
  endtask

  task automatic chk_reset_vals(input string tag);
    check({tag, "_val"},   32'(cnt_val),    32'hF);
    check({tag, "_vld"},   32'(cnt_valid),  32'h0);
    check({tag, "_step"},  32'(step_pulse), 32'h0);
    check({tag, "_wrap"},  32'(wrap_pulse), 32'h0);
    check({tag, "_wcnt"},  32'(wrap_count), 32'h0);
    check({tag, "_err"},   32'(err),        32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int w0;
    Reset  = 1'b1;
    clear  = 1'b0;
    cnt_in = 4'hF;
    #1;
    chk_reset_vals("rst");
    cyc(2);
    Reset = 1'b0;

    // 1: acquire the reset value
    cyc(3);
    check("s1_vld",  32'(cnt_valid), 32'h1);
    check("s1_val",  32'(cnt_val),   32'hF);
    check("s1_step", 32'(nstep),     32'h0);
    check("s1_err",  32'(err),       32'h0);
    cyc(1);

    // 2: two steps, with latency and width checked on the first
    cnt_in = 4'hE;
    cyc(2);
    check("s2_lat2", 32'(step_pulse), 32'h0);
    cyc(1);
    check("s2_lat3", 32'(step_pulse), 32'h1);
    check("s2_val",  32'(cnt_val),    32'hE);
    cyc(1);
    check("s2_wid",  32'(step_pulse), 32'h0);
    hold(4'hD, 4);
    check("s2_nstp", 32'(nstep),  32'h2);
    check("s2_nwrp", 32'(nwrap),  32'h0);
    check("s2_dbl",  32'(ndbl),   32'h0);

    // 3: walk down through the wrap
    for (int v = 12; v >= 0; v--) hold(4'(v), 4);
    check("s3_val0", 32'(cnt_val),    32'h0);
    check("s3_wc0",  32'(wrap_count), 32'h0);
    s0 = nstep;
    cnt_in = 4'hF;
    cyc(2);
    check("s3_nowr", 32'(wrap_pulse), 32'h0);
    cyc(1);
    check("s3_step", 32'(step_pulse), 32'h1);
    check("s3_wrap", 32'(wrap_pulse), 32'h1);
    check("s3_wc1",  32'(wrap_count), 32'h1);
    cyc(1);
    check("s3_nstp", 32'(nstep - s0), 32'h1);

    // 4: filtered glitch, then a skipped count
    for (int v = 14; v >= 4; v--) hold(4'(v), 4);
    s0 = nstep;
    hold(4'h7, 1);
    hold(4'h3, 4);
    check("s4_noerr", 32'(err),         32'h0);
    check("s4_step",  32'(nstep - s0),  32'h1);
    check("s4_val",   32'(cnt_val),     32'h3);
    s0 = nstep;
    w0 = nwrap;
    hold(4'h0, 4);
    check("s4_err",   32'(err),         32'h1);
    check("s4_val0",  32'(cnt_val),     32'h0);
    check("s4_nostp", 32'(nstep - s0),  32'h0);
    hold(4'hF, 4);
    hold(4'hE, 4);
    check("s4_erstp", 32'(nstep - s0),  32'h0);
    check("s4_erwrp", 32'(nwrap - w0),  32'h0);
    check("s4_wcfz",  32'(wrap_count),  32'h1);
    check("s4_follw", 32'(cnt_val),     32'hE);
    check("s4_stick", 32'(err),         32'h1);

    // 5: saturate the 2-bit tally, then clear on a wrap
    hold(4'hF, 2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("s5_clerr", 32'(err),        32'h0);
    check("s5_clvld", 32'(cnt_valid),  32'h0);
    check("s5_clwc",  32'(wrap_count), 32'h0);
    cyc(1);
    check("s5_reacq", 32'(cnt_valid),  32'h1);
    w0 = nwrap;
    for (int k = 0; k < 5; k++) begin
      for (int v = 14; v >= 0; v--) hold(4'(v), 4);
      hold(4'hF, 4);
    end
    check("s5_sat",   32'(wrap_count), 32'h3);
    check("s5_nwrp",  32'(nwrap - w0), 32'h5);
    check("s5_err",   32'(err),        32'h0);
    for (int v = 14; v >= 0; v--) hold(4'(v), 4);
    check("s5_hold3", 32'(wrap_count), 32'h3);
    cnt_in = 4'hF;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("s5_cwrp",  32'(wrap_pulse), 32'h0);
    check("s5_cstp",  32'(step_pulse), 32'h0);
    check("s5_cwc",   32'(wrap_count), 32'h0);
    check("s5_cvld",  32'(cnt_valid),  32'h0);
    check("s5_cval",  32'(cnt_val),    32'h0);
    cyc(1);
    check("s5_rvld",  32'(cnt_valid),  32'h1);
    check("s5_rval",  32'(cnt_val),    32'hF);
    check("s5_dbl",   32'(ndbl),       32'h0);

    // 6: asynchronous reset while in ERROR
    hold(4'h5, 4);
    check("s6_err",   32'(err),     32'h1);
    check("s6_val",   32'(cnt_val), 32'h5);
    #2;
    Reset = 1'b1;
    #1;
    chk_reset_vals("s6_arst");
    cnt_in = 4'hF;
    cyc(2);
    Reset = 1'b0;
    s0 = nstep;
    cyc(3);
    check("s6_vld",   32'(cnt_valid),  32'h1);
    check("s6_rval",  32'(cnt_val),    32'hF);
    check("s6_rerr",  32'(err),        32'h0);
    check("s6_rwc",   32'(wrap_count), 32'h0);
    check("s6_nstp",  32'(nstep - s0), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
